random_coord_gen: RTL

- Consumes the free-running 16-bit LFSR word from the random-number stage.
- Converts it into uniformly distributed on-screen sprite coordinates (x in [0,H_MAX), y in [0,V_MAX)) using rejection sampling.
- Buffers finished coordinate pairs in a small FIFO.
- Sprite/object placement logic pops pairs through a valid/ready handshake, so it never waits on rejection loops.

---
 rtl/random_coord_gen_pkg.sv | 18 +
 rtl/random_coord_gen_if.sv | 28 ++
 rtl/coord_fifo.sv | 56 +++++
 rtl/random_coord_gen.sv | 120 ++++++++++++
 4 files changed

// File: rtl/random_coord_gen_pkg.sv
// Shared screen constants, coordinate widths and generator state encoding.
package random_coord_gen_pkg;

   // Visible screen area; default exclusive bounds for generated coordinates.
   localparam int H_ACTIVE = 640;
   localparam int V_ACTIVE = 480;

   // Coordinate widths wide enough to hold H_ACTIVE-1 and V_ACTIVE-1.
   localparam int X_W = 10;
   localparam int Y_W = 9;

   // S_X: waiting for an acceptable x sample; S_Y: x held, waiting for y.
   typedef enum logic {
      S_X = 1'b0,
      S_Y = 1'b1
   } state_t;

endpackage

// File: rtl/random_coord_gen_if.sv
// Coordinate output stream.
// Handshake: the producer holds out_valid high while an entry is at the head;
// out_x/out_y are stable whenever out_valid is high; one entry transfers on
// every clock edge where out_valid && out_ready; out_ready while out_valid is
// low has no effect.
interface random_coord_gen_if #(
   parameter int X_W = random_coord_gen_pkg::X_W,
   parameter int Y_W = random_coord_gen_pkg::Y_W
);
   logic           out_valid;
   logic           out_ready;
   logic [X_W-1:0] out_x;
   logic [Y_W-1:0] out_y;

   modport master (
      output out_valid,
      output out_x,
      output out_y,
      input  out_ready
   );

   modport slave (
      input  out_valid,
      input  out_x,
      input  out_y,
      output out_ready
   );
endinterface

// File: rtl/coord_fifo.sv
// Small show-ahead FIFO with synchronous reset; dout always shows the head.
module coord_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 19
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);
   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic             do_push;
   logic             do_pop;

   // Pop on empty is ignored; push on full only lands if a pop frees the slot.
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   assign full  = (count == (PTR_W+1)'(DEPTH));
   assign empty = (count == '0);
   assign dout  = mem[rd_ptr];

   // Storage, pointers (wrap modulo DEPTH) and occupancy count.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end
endmodule

// File: rtl/random_coord_gen.sv
// Turns a free-running LFSR word into uniform (x, y) screen coordinates by
// rejection sampling and queues finished pairs for the sprite placer.
module random_coord_gen
   import random_coord_gen_pkg::*;
#(
   parameter int H_MAX = random_coord_gen_pkg::H_ACTIVE,
   parameter int V_MAX = random_coord_gen_pkg::V_ACTIVE,
   parameter int X_W   = random_coord_gen_pkg::X_W,
   parameter int Y_W   = random_coord_gen_pkg::Y_W,
   parameter int GAP   = 16,
   parameter int DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [15:0]          random,
   random_coord_gen_if.master   out_bus,
   output logic [7:0]           reject_count,
   output state_t               state
);
   localparam int GAP_W = $clog2(GAP);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP - 1);

   state_t               state_q;
   state_t               state_nxt;
   logic [GAP_W-1:0]     gap_cnt;
   logic [GAP_W-1:0]     gap_nxt;
   logic [X_W-1:0]       x_hold;
   logic [X_W-1:0]       x_hold_nxt;
   logic                 reject;
   logic                 push;
   logic                 sample;
   logic [X_W-1:0]       x_cand;
   logic [Y_W-1:0]       y_cand;
   logic [X_W+Y_W-1:0]   fifo_dout;
   logic [$clog2(DEPTH):0] fifo_count;
   logic                 fifo_full;
   logic                 fifo_empty;

   // Upper LFSR bits and the occupancy count are not needed here.
   wire unused_bits = ^{random[15:X_W], fifo_count};

   assign x_cand = random[X_W-1:0];
   assign y_cand = random[Y_W-1:0];
   assign sample = (gap_cnt == GAP_LAST);
   assign state  = state_q;

   // Next-state logic: sample every GAP cycles, accept in-range candidates.
   always_comb begin
      state_nxt  = state_q;
      gap_nxt    = gap_cnt;
      x_hold_nxt = x_hold;
      reject     = 1'b0;
      push       = 1'b0;
      case (state_q)
         S_X: begin
            // Freeze while full so a pair is never built without a free slot.
            if (!fifo_full) begin
               gap_nxt = sample ? '0 : gap_cnt + 1'b1;
               if (sample) begin
                  if (32'(x_cand) < H_MAX) begin
                     x_hold_nxt = x_cand;
                     state_nxt  = S_Y;
                  end else begin
                     reject = 1'b1;
                  end
               end
            end
         end
         S_Y: begin
            // A slot is already reserved: count only shrinks while in S_Y.
            gap_nxt = sample ? '0 : gap_cnt + 1'b1;
            if (sample) begin
               if (32'(y_cand) < V_MAX) begin
                  push      = 1'b1;
                  state_nxt = S_X;
               end else begin
                  reject = 1'b1;
               end
            end
         end
         default: state_nxt = S_X;
      endcase
   end

   // State, sample timer, held x and saturating reject counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_X;
         gap_cnt      <= '0;
         x_hold       <= '0;
         reject_count <= '0;
      end else begin
         state_q <= state_nxt;
         gap_cnt <= gap_nxt;
         x_hold  <= x_hold_nxt;
         if (reject && (reject_count != 8'hFF)) begin
            reject_count <= reject_count + 8'd1;
         end
      end
   end

   coord_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (X_W + Y_W)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (out_bus.out_ready),
      .din   ({x_hold, y_cand}),
      .dout  (fifo_dout),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign out_bus.out_valid = !fifo_empty;
   assign out_bus.out_x     = fifo_dout[X_W+Y_W-1:Y_W];
   assign out_bus.out_y     = fifo_dout[Y_W-1:0];
endmodule
